// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage -- RV32IM execute stage with EX/MEM pipeline register.
//
// Computes the ALU / single-cycle multiply result, resolves branches and jumps,
// and runs a 32-step iterative radix-2 divider for DIV/DIVU/REM/REMU. While a
// divide is in flight the stage raises ex_stall so the front end holds the
// instruction in ID/EX.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   id_ex_*                     decoded instruction, operands and control from ID/EX
//   flush                       kill the instruction currently in EX
//   ex_stall                    hold IF/ID and ID/EX (divide in progress)
//   branch_taken/branch_target  redirect request for taken branches and jumps
//   ex_mem_*                    registered EX/MEM pipeline outputs (bubble = all zero)
// -----------------------------------------------------------------------------
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ex_valid,
  input  logic [31:0] id_ex_pc,
  input  logic [31:0] id_ex_pc_4,
  input  logic [31:0] id_ex_rs1_data,
  input  logic [31:0] id_ex_rs2_data,
  input  logic [31:0] id_ex_imm,
  input  logic [4:0]  id_ex_rd,
  input  logic [2:0]  id_ex_funct3,
  input  logic [6:0]  id_ex_funct7,
  input  logic [6:0]  id_ex_opcode,
  input  logic        id_ex_alu_src_imm,
  input  logic        id_ex_mem_write_en,
  input  logic        id_ex_mem_read_en,
  input  logic        id_ex_reg_write_en,
  input  logic [1:0]  id_ex_mem_to_reg_sel,
  input  logic        flush,
  output logic        ex_stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic [31:0] ex_mem_pc,
  output logic [31:0] ex_mem_pc_4,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_rs2_data,
  output logic [4:0]  ex_mem_rd,
  output logic [2:0]  ex_mem_funct3,
  output logic [6:0]  ex_mem_opcode,
  output logic        ex_mem_mem_write_en,
  output logic        ex_mem_mem_read_en,
  output logic        ex_mem_reg_write_en,
  output logic [1:0]  ex_mem_mem_to_reg_sel
);

  localparam int DATA_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t state, state_next;

  // Two's-complement negate when n is set; used for operand magnitudes and
  // for restoring the sign of divider results.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Operand selection
  logic        [DATA_W-1:0] op_a, op_b;
  logic signed [DATA_W-1:0] op_a_s, op_b_s;

  assign op_a   = id_ex_rs1_data;
  assign op_b   = id_ex_alu_src_imm ? id_ex_imm : id_ex_rs2_data;
  assign op_a_s = op_a;
  assign op_b_s = op_b;

  logic is_mext, is_div, div_present, div_start;

  assign is_mext     = (id_ex_opcode == OP_R) && (id_ex_funct7 == 7'b0000001);
  assign is_div      = is_mext && id_ex_funct3[2];
  assign div_present = id_ex_valid && is_div;
  assign div_start   = (state == S_IDLE) && div_present && !flush;

  // Multiplier: 64-bit products; only the low 64 bits matter, so the
  // sign/zero-extended operands give the RV32M signedness variants directly.
  logic signed [2*DATA_W-1:0] a_sx, b_sx, b_zx;
  logic signed [2*DATA_W-1:0] prod_ss, prod_su;
  logic        [2*DATA_W-1:0] prod_uu;
  logic        [DATA_W-1:0]   mulhsu_hi, mulhu_hi;

  assign a_sx      = {{DATA_W{op_a[DATA_W-1]}}, op_a};
  assign b_sx      = {{DATA_W{op_b[DATA_W-1]}}, op_b};
  assign b_zx      = {{DATA_W{1'b0}}, op_b};
  assign prod_ss   = a_sx * b_sx;
  assign prod_su   = a_sx * b_zx;
  assign prod_uu   = {{DATA_W{1'b0}}, op_a} * {{DATA_W{1'b0}}, op_b};
  assign mulhsu_hi = DATA_W'(prod_su >> DATA_W);
  assign mulhu_hi  = DATA_W'(prod_uu >> DATA_W);

  // Divider state
  logic [4:0]        div_count;
  logic [DATA_W-1:0] div_q, div_r, div_d, div_dividend;
  logic              div_neg_q, div_neg_r, div_rem, div_zero;
  logic              div_signed, neg_a, neg_b;
  logic [DATA_W:0]   step_shift;
  logic              step_ge;
  logic [DATA_W-1:0] step_sub;
  logic [DATA_W-1:0] div_quot, div_remainder, div_result;

  assign div_signed = !id_ex_funct3[0];
  assign neg_a      = div_signed && op_a[DATA_W-1];
  assign neg_b      = div_signed && op_b[DATA_W-1];

  // Restoring step: the partial remainder is always below the divisor, so the
  // 32-bit difference is exact whenever the shifted value is >= divisor.
  assign step_shift = {div_r, div_q[DATA_W-1]};
  assign step_ge    = step_shift >= {1'b0, div_d};
  assign step_sub   = step_shift[DATA_W-1:0] - div_d;

  // Divide-by-zero bypasses sign correction so the quotient stays all ones and
  // the remainder is the raw dividend. INT_MIN / -1 falls out naturally.
  assign div_quot      = div_zero ? '1 : cond_neg(div_q, div_neg_q);
  assign div_remainder = div_zero ? div_dividend : cond_neg(div_r, div_neg_r);
  assign div_result    = div_rem ? div_remainder : div_quot;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (div_start) state_next = S_BUSY;
      S_BUSY: begin
        if (flush)                  state_next = S_IDLE;
        else if (div_count == 5'd31) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ex_stall = ((state == S_IDLE) && div_present) || (state == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst)                  div_count <= '0;
    else if (div_start)       div_count <= '0;
    else if (state == S_BUSY) div_count <= div_count + 5'd1;
  end

  // Divider datapath: operands latched on entry to BUSY, so later ID/EX
  // changes have no effect on the result.
  always_ff @(posedge clk) begin
    if (div_start) begin
      div_q        <= cond_neg(op_a, neg_a);
      div_d        <= cond_neg(op_b, neg_b);
      div_r        <= '0;
      div_dividend <= op_a;
      div_neg_q    <= neg_a ^ neg_b;
      div_neg_r    <= neg_a;
      div_rem      <= id_ex_funct3[1];
      div_zero     <= (op_b == '0);
    end else if (state == S_BUSY) begin
      div_q <= {div_q[DATA_W-2:0], step_ge};
      div_r <= step_ge ? step_sub : step_shift[DATA_W-1:0];
    end
  end

  // ALU result
  logic [DATA_W-1:0] alu_result;
  logic              is_sub, is_sra;

  assign is_sub = (id_ex_opcode == OP_R) && id_ex_funct7[5];
  assign is_sra = id_ex_funct7[5];

  always_comb begin
    alu_result = '0;
    case (id_ex_opcode)
      OP_R, OP_I: begin
        if (is_mext) begin
          case (id_ex_funct3)
            3'd0:    alu_result = prod_ss[DATA_W-1:0];
            3'd1:    alu_result = prod_ss[2*DATA_W-1:DATA_W];
            3'd2:    alu_result = mulhsu_hi;
            3'd3:    alu_result = mulhu_hi;
            default: alu_result = div_result;
          endcase
        end else begin
          case (id_ex_funct3)
            3'd0: alu_result = is_sub ? (op_a - op_b) : (op_a + op_b);
            3'd1: alu_result = op_a << op_b[4:0];
            3'd2: alu_result = {{(DATA_W-1){1'b0}}, (op_a_s < op_b_s)};
            3'd3: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
            3'd4: alu_result = op_a ^ op_b;
            3'd5: alu_result = is_sra ? DATA_W'(op_a_s >>> op_b[4:0]) : (op_a >> op_b[4:0]);
            3'd6: alu_result = op_a | op_b;
            default: alu_result = op_a & op_b;
          endcase
        end
      end
      OP_LUI:            alu_result = id_ex_imm;
      OP_AUIPC:          alu_result = id_ex_pc + id_ex_imm;
      OP_LOAD, OP_STORE: alu_result = op_a + id_ex_imm;
      default:           alu_result = '0;
    endcase
  end

  // Branch resolution compares the register operands, never the immediate.
  logic signed [DATA_W-1:0] rs2_s;
  logic                     br_cond, is_jal, is_jalr, redirect;

  assign rs2_s = id_ex_rs2_data;

  always_comb begin
    br_cond = 1'b0;
    case (id_ex_funct3)
      3'b000:  br_cond = (op_a == id_ex_rs2_data);
      3'b001:  br_cond = (op_a != id_ex_rs2_data);
      3'b100:  br_cond = (op_a_s < rs2_s);
      3'b101:  br_cond = (op_a_s >= rs2_s);
      3'b110:  br_cond = (op_a < id_ex_rs2_data);
      3'b111:  br_cond = (op_a >= id_ex_rs2_data);
      default: br_cond = 1'b0;
    endcase
  end

  assign is_jal        = (id_ex_opcode == OP_JAL);
  assign is_jalr       = (id_ex_opcode == OP_JALR);
  assign redirect      = ((id_ex_opcode == OP_BRANCH) && br_cond) || is_jal || is_jalr;
  assign branch_taken  = id_ex_valid && !ex_stall && !flush && redirect;
  assign branch_target = is_jalr ? ((op_a + id_ex_imm) & ~32'd1) : (id_ex_pc + id_ex_imm);

  // EX -> MEM boundary: anything not cleanly issued becomes an all-zero bubble.
  logic vld_p0;

  assign vld_p0 = id_ex_valid && !ex_stall && !flush;

  always_ff @(posedge clk) begin
    if (rst || !vld_p0) begin
      ex_mem_pc             <= '0;
      ex_mem_pc_4           <= '0;
      ex_mem_alu_result     <= '0;
      ex_mem_rs2_data       <= '0;
      ex_mem_rd             <= '0;
      ex_mem_funct3         <= '0;
      ex_mem_opcode         <= '0;
      ex_mem_mem_write_en   <= 1'b0;
      ex_mem_mem_read_en    <= 1'b0;
      ex_mem_reg_write_en   <= 1'b0;
      ex_mem_mem_to_reg_sel <= '0;
    end else begin
      ex_mem_pc             <= id_ex_pc;
      ex_mem_pc_4           <= id_ex_pc_4;
      ex_mem_alu_result     <= alu_result;
      ex_mem_rs2_data       <= id_ex_rs2_data;
      ex_mem_rd             <= id_ex_rd;
      ex_mem_funct3         <= id_ex_funct3;
      ex_mem_opcode         <= id_ex_opcode;
      ex_mem_mem_write_en   <= id_ex_mem_write_en;
      ex_mem_mem_read_en    <= id_ex_mem_read_en;
      ex_mem_reg_write_en   <= id_ex_reg_write_en;
      ex_mem_mem_to_reg_sel <= id_ex_mem_to_reg_sel;
    end
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, reset, synchronous, active-high.
REQ-002 SHALL have inputs from ID/EX: id_ex_valid 1, instruction present; id_ex_pc, id_ex_pc_4, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm 32 each; id_ex_rd 5; id_ex_funct3 3; id_ex_funct7 7; id_ex_opcode 7.
REQ-003 SHALL have control inputs: id_ex_alu_src_imm 1, operand B is imm; id_ex_mem_write_en, id_ex_mem_read_en, id_ex_reg_write_en 1 each; id_ex_mem_to_reg_sel 2.
REQ-004 SHALL have input flush 1 from the hazard unit, which kills the instruction in EX.
REQ-005 SHALL have outputs: ex_stall 1, hold IF/ID/ID-EX; branch_taken 1; branch_target 32.
REQ-006 SHALL have registered outputs: ex_mem_pc, ex_mem_pc_4, ex_mem_alu_result, ex_mem_rs2_data 32 each; ex_mem_rd 5; ex_mem_funct3 3; ex_mem_opcode 7; ex_mem_mem_write_en, ex_mem_mem_read_en, ex_mem_reg_write_en 1 each; ex_mem_mem_to_reg_sel 2.

Function
REQ-007 SHALL compute B = id_ex_alu_src_imm ? id_ex_imm : id_ex_rs2_data.
REQ-008 SHALL implement RV32I ALU for opcodes 0110011 (R) and 0010011 (I): ADD/SUB (SUB only R-type with funct7[5]=1), SLL/SRL/SRA (shift amount B[4:0]), SLT, SLTU, XOR, OR, AND.
REQ-009 SHALL produce alu_result: LUI 0110111 = imm; AUIPC 0010111 = pc+imm; load 0000011/store 0100011 = rs1+imm; JAL/JALR = don't-care (link uses pc_4 downstream).
REQ-010 SHALL, for R-type funct7=0000001 funct3 0-3, produce MUL/MULH/MULHSU/MULHU (low or high 32 bits of 64-bit product, signedness per RV32M) in the same cycle.
REQ-011 SHALL, for R-type funct7=0000001 funct3 4-7 (DIV/DIVU/REM/REMU), use an iterative radix-2 divider on operand magnitudes with sign correction (quotient sign = sign(a) xor sign(b); remainder sign = sign(a)).
REQ-012 SHALL implement divider FSM IDLE/BUSY/DONE: IDLE->BUSY when a valid, unflushed divide is in EX (latch operands, count=0); BUSY increments count, BUSY->DONE after 32 BUSY cycles; DONE->IDLE unconditionally.
REQ-013 SHALL assert ex_stall combinationally when (IDLE and valid divide present) or state==BUSY; ex_stall SHALL be 0 in DONE.
REQ-014 SHALL give a divide 34 cycles in EX: arrival, 32 BUSY, DONE; EX/MEM captures the result at the DONE-cycle edge.
REQ-015 SHALL, for divisor 0, return quotient 0xFFFFFFFF and remainder = dividend; for DIV/REM of 0x80000000 by 0xFFFFFFFF, return quotient 0x80000000 and remainder 0; both after the full 34-cycle latency.
REQ-016 SHALL resolve branches (opcode 1100011) by funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; other funct3 not taken.
REQ-017 SHALL drive branch_taken = id_ex_valid & ~ex_stall & ~flush & (taken branch | JAL 1101111 | JALR 1100111).
REQ-018 SHALL drive branch_target: branch/JAL = pc+imm; JALR = (rs1+imm) & 0xFFFFFFFE.
REQ-019 SHALL, each non-reset edge with ex_stall=0, valid=1 and flush=0, load EX/MEM with pc, pc_4, alu_result, rs2_data, rd, funct3, opcode and the control inputs.
REQ-020 SHALL otherwise (ex_stall=1, valid=0 or flush=1) load a bubble: every ex_mem_* output = 0.
REQ-021 SHALL, on flush=1 in BUSY or DONE, return the FSM to IDLE at the next edge, discard the divide and load a bubble.
REQ-022 SHALL ignore id_ex_* changes while BUSY; operands are the values latched on entry to BUSY.

Reset
REQ-023 SHALL, when rst=1 at an edge, zero all ex_mem_* registers, set the FSM to IDLE, count 0; ex_stall and branch_taken then depend only on inputs.
REQ-024 SHALL abort an in-progress divide on rst with no result written.

Verification
REQ-025 ADD rs1=5, rs2=0xFFFFFFFD, valid -> next edge ex_mem_alu_result=2, rd/control copied, ex_stall=0.
REQ-026 DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> ex_stall high 33 cycles; at the 34th edge ex_mem_alu_result=0xFFFFFFFD; REM gives 0xFFFFFFFF.
REQ-027 DIVU by 0, rs1=0x1234 -> 0xFFFFFFFF; REMU by 0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
REQ-028 BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> branch_taken=1, target 0x120; BLTU same operands -> branch_taken=0.
REQ-029 JALR rs1=0x1001, imm=2 -> target 0x1002; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 Flush at BUSY count 10 and rst at count 20 of a second divide -> each gives IDLE next cycle, ex_stall=0 with no divide presented, EX/MEM bubble, no result written.
